// File: rtl/core_ctrl_if.sv
// core_ctrl_if: input-stream handshake, ofifo status and instruction word between core_ctrl and core
interface core_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        fifo_valid;
  logic [19:0] inst;
  modport master(output in_valid, output fifo_valid, input in_ready, input inst);
  modport slave(input in_valid, input fifo_valid, output in_ready, output inst);
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl: instruction sequencer producing the core inst word for one attention tile
module core_ctrl #(
  parameter int col = 8,
  parameter int pr  = 16,
  parameter int bw  = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   n_q,
  core_ctrl_if.slave   bus,
  output logic         busy,
  output logic         done,
  output logic [3:0]   state
);
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    QWR   = 4'd1,
    KWR   = 4'd2,
    KLOAD = 4'd3,
    KGAP  = 4'd4,
    EXEC  = 4'd5,
    DRAIN = 4'd6,
    OREAD = 4'd7,
    NORM  = 4'd8,
    DONE  = 4'd9
  } state_t;

  if (col < 1 || col > 16 || pr * bw < 1) begin : g_bad_cfg
    $error("core_ctrl: col must be 1..16 and pr*bw positive");
  end

  state_t      st, st_d;
  logic [4:0]  cnt, cnt_d;
  logic [1:0]  ph, ph_d;
  logic [3:0]  nq, nq_d;
  logic [19:0] inst_q, inst_d;
  logic        last_q;

  assign last_q       = cnt == {1'b0, nq};
  assign bus.in_ready = (st == QWR) || (st == KWR);
  assign bus.inst     = inst_q;
  assign busy         = st != IDLE;
  assign done         = st == DONE;
  assign state        = st;

  // State, counters and the instruction word; the word issued for a cycle's
  // action appears after the following edge, so core sees mem_in one cycle
  // after the handshake that produced the write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= IDLE;
      cnt    <= '0;
      ph     <= '0;
      nq     <= '0;
      inst_q <= '0;
    end else begin
      st     <= st_d;
      cnt    <= cnt_d;
      ph     <= ph_d;
      nq     <= nq_d;
      inst_q <= inst_d;
    end
  end

  // Next state, counter updates and the instruction bits for the current state
  always_comb begin
    st_d   = st;
    cnt_d  = cnt;
    ph_d   = ph;
    nq_d   = nq;
    inst_d = '0;
    case (st)
      IDLE: begin
        if (start) begin
          nq_d  = n_q;
          cnt_d = '0;
          st_d  = QWR;
        end
      end
      QWR: begin
        if (bus.in_valid) begin
          inst_d[4]     = 1'b1;
          inst_d[15:12] = cnt[3:0];
          cnt_d         = last_q ? 5'd0 : cnt + 5'd1;
          st_d          = last_q ? KWR : QWR;
        end
      end
      KWR: begin
        if (bus.in_valid) begin
          inst_d[2]     = 1'b1;
          inst_d[15:12] = cnt[3:0];
          cnt_d         = (cnt == 5'(col - 1)) ? 5'd0 : cnt + 5'd1;
          st_d          = (cnt == 5'(col - 1)) ? KLOAD : KWR;
        end
      end
      KLOAD: begin
        inst_d[3]     = cnt < 5'(col);
        inst_d[15:12] = (cnt < 5'(col)) ? cnt[3:0] : 4'd0;
        inst_d[6]     = cnt != 5'd0;
        cnt_d         = (cnt == 5'(col)) ? 5'd0 : cnt + 5'd1;
        st_d          = (cnt == 5'(col)) ? KGAP : KLOAD;
      end
      KGAP: begin
        cnt_d = (cnt == 5'd1) ? 5'd0 : cnt + 5'd1;
        st_d  = (cnt == 5'd1) ? EXEC : KGAP;
      end
      EXEC: begin
        inst_d[5]     = cnt <= {1'b0, nq};
        inst_d[15:12] = (cnt <= {1'b0, nq}) ? cnt[3:0] : 4'd0;
        inst_d[7]     = cnt != 5'd0;
        cnt_d         = (cnt == {1'b0, nq} + 5'd1) ? 5'd0 : cnt + 5'd1;
        st_d          = (cnt == {1'b0, nq} + 5'd1) ? DRAIN : EXEC;
      end
      DRAIN: begin
        st_d = bus.fifo_valid ? OREAD : DRAIN;
      end
      OREAD: begin
        if (bus.fifo_valid) begin
          inst_d[16]   = 1'b1;
          inst_d[0]    = 1'b1;
          inst_d[11:8] = cnt[3:0];
          cnt_d        = last_q ? 5'd0 : cnt + 5'd1;
          st_d         = last_q ? NORM : OREAD;
        end
      end
      NORM: begin
        inst_d[11:8] = cnt[3:0];
        inst_d[1]    = ph == 2'd0;
        inst_d[17]   = ph == 2'd1;
        inst_d[18]   = ph == 2'd2;
        inst_d[0]    = ph == 2'd2;
        ph_d         = (ph == 2'd2) ? 2'd0 : ph + 2'd1;
        cnt_d        = (ph != 2'd2) ? cnt : last_q ? 5'd0 : cnt + 5'd1;
        st_d         = (ph == 2'd2 && last_q) ? DONE : NORM;
      end
      DONE: begin
        st_d = IDLE;
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end
endmodule
